// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit universal shift register.
// Modes: hold, shift left, shift right, parallel load, plus synchronous set.
// A multi-cycle burst shift moves the register by amt positions over amt clocks.
// While it runs, busy is high. A one-cycle done pulse follows the last shift.
// Optional build macro USR_ROTATE_EN adds the rot input.
// When rot=1, shifts recirculate the bit that falls off the end instead of taking sin_r/sin_l.
//
// Handshake: start is honoured only while IDLE with mode 01/10 and amt != 0.
// busy rises on the edge that accepts start and stays high for exactly N = min(amt, WIDTH) cycles.
// done is high for the single cycle after busy falls.
// A new start presented while done is high is accepted.
// reset_n and set_n abort a burst without pulsing done.
module universal_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter int               AMT_W     = 4,
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
`ifdef USR_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  // Elaboration-time sanity checks on the parameters.
  if (WIDTH < 2) begin : g_bad_width
    $error("universal_shift_reg: WIDTH must be >= 2");
  end
  if ((1 << AMT_W) <= WIDTH) begin : g_bad_amt_w
    $error("universal_shift_reg: AMT_W too small to hold WIDTH");
  end

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_right_q, dir_right_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             rot_sel;
  logic             fill_l;      // bit entering position 0 on a left shift
  logic             fill_r;      // bit entering position WIDTH-1 on a right shift
  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic             burst_go;
  logic [AMT_W-1:0] amt_clamped;

`ifdef USR_ROTATE_EN
  assign rot_sel = rot;
`else
  assign rot_sel = 1'b0;
`endif

  // Shift candidates, with serial or recirculated fill bits.
  always_comb begin
    fill_l  = rot_sel ? q_q[WIDTH-1] : sin_r;
    fill_r  = rot_sel ? q_q[0]       : sin_l;
    shl_val = {q_q[WIDTH-2:0], fill_l};
    shr_val = {fill_r, q_q[WIDTH-1:1]};
  end

  // Burst acceptance qualifier and the shift count clamped to WIDTH.
  always_comb begin
    burst_go    = start && ((mode == MODE_SHL) || (mode == MODE_SHR)) && (amt != '0);
    amt_clamped = (int'(amt) > WIDTH) ? AMT_W'(WIDTH) : amt;
  end

  // Next-state logic: set, then burst, then the single-cycle en/mode rule.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    dir_right_d = dir_right_q;
    busy_d      = busy_q;
    done_d      = 1'b0;           // done never lasts more than one cycle
    if (!set_n) begin
      q_d     = SET_VALUE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (burst_go) begin
            // q is left untouched on the accepting edge; shifting starts next edge.
            dir_right_d = (mode == MODE_SHR);
            cnt_d       = amt_clamped;
            busy_d      = 1'b1;
            state_d     = ST_BURST;
          end else if (en) begin
            case (mode)
              MODE_HOLD: q_d = q_q;
              MODE_SHL:  q_d = shl_val;
              MODE_SHR:  q_d = shr_val;
              MODE_LOAD: q_d = d;
              default:   q_d = q_q;
            endcase
          end
        end
        ST_BURST: begin
          q_d   = dir_right_q ? shr_val : shl_val;
          cnt_d = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset taking top priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      q_q         <= '0;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      dir_right_q <= dir_right_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg (default WIDTH=8, AMT_W=4).
// Compile with +define+USR_ROTATE_EN to exercise the rotate build.
module tb_universal_shift_reg;

  localparam int W  = 8;
  localparam int AW = 4;
  localparam int EW = W + 4;
  localparam logic [W-1:0] SETV = {W{1'b1}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, set_n, en, sin_r, sin_l, start;
  logic [1:0]    mode;
  logic [W-1:0]  d;
  logic [AW-1:0] amt;
  logic          rot;
  logic [W-1:0]  q;
  logic          sout_l, sout_r, busy, done;

  universal_shift_reg #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .set_n(set_n), .en(en), .mode(mode),
    .d(d), .sin_r(sin_r), .sin_l(sin_l), .start(start), .amt(amt),
`ifdef USR_ROTATE_EN
    .rot(rot),
`endif
    .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            total = 0;
  int            bad   = 0;

  // ---------------- reference model ----------------
  longint unsigned m_q;
  bit              m_busy, m_done, m_right;
  int              m_left;

  function automatic longint unsigned pow2(input int n);
    return longint'(1) << n;
  endfunction

  // One shift: left doubles the value, right halves it.
  // The vacated end is filled from the serial input, or from the bit that fell off when rotating.
  function automatic longint unsigned model_shift(input longint unsigned v, input bit right,
                                                  input bit rotate, input bit sr, input bit sl);
    longint unsigned fill;
    if (!right) begin
      fill = rotate ? (v / pow2(W-1)) : longint'(sr);
      return ((v * 2) % pow2(W)) + fill;
    end else begin
      fill = rotate ? (v % 2) : longint'(sl);
      return (v / 2) + fill * pow2(W-1);
    end
  endfunction

  // Apply one clock edge to the model using the current inputs, then queue the expected outputs.
  task automatic model_edge(input string name);
    bit rotate;
    logic [W-1:0] qv;
`ifdef USR_ROTATE_EN
    rotate = rot;
`else
    rotate = 1'b0;
`endif
    if (!reset_n) begin
      m_q = 0; m_busy = 0; m_done = 0; m_left = 0;
    end else if (!set_n) begin
      m_q = longint'(SETV); m_busy = 0; m_done = 0; m_left = 0;
    end else if (m_busy) begin
      m_q    = model_shift(m_q, m_right, rotate, sin_r, sin_l);
      m_left = m_left - 1;
      m_busy = (m_left != 0);
      m_done = (m_left == 0);
    end else begin
      m_done = 0;
      if (start && (mode == 2'b01 || mode == 2'b10) && amt != 0) begin
        m_left  = (int'(amt) > W) ? W : int'(amt);
        m_right = (mode == 2'b10);
        m_busy  = 1;
      end else if (en) begin
        if (mode == 2'b01)      m_q = model_shift(m_q, 1'b0, rotate, sin_r, sin_l);
        else if (mode == 2'b10) m_q = model_shift(m_q, 1'b1, rotate, sin_r, sin_l);
        else if (mode == 2'b11) m_q = longint'(d);
      end
    end
    qv = m_q[W-1:0];
    exp_q.push_back({qv, qv[W-1], qv[0], m_busy, m_done});
    name_q.push_back(name);
  endtask

  // ---------------- driver ----------------
  // Inputs are set by the caller on the falling edge; this records the expectation and spends one cycle.
  task automatic step(input string name);
    model_edge(name);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset_n = 1; set_n = 1; en = 0; mode = 2'b00; d = '0;
    sin_r = 0; sin_l = 0; start = 0; amt = '0; rot = 0;
  endtask

  task automatic load(input logic [W-1:0] v);
    en = 1; mode = 2'b11; d = v; start = 0;
    step("load");
    en = 0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e, g;
    string         nm;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        g  = {q, sout_l, sout_r, busy, done};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL %s: got q=%h sl=%b sr=%b busy=%b done=%b, want q=%h sl=%b sr=%b busy=%b done=%b",
                   nm, g[EW-1:4], g[3], g[2], g[1], g[0], e[EW-1:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    m_q = 0; m_busy = 0; m_done = 0; m_left = 0; m_right = 0;

    // Reset across an edge.
    reset_n = 0;
    step("reset");
    reset_n = 1;
    step("reset_hold");

    // A reset pulse that ends before the edge changes nothing.
    load(8'hA5);
    reset_n = 0; #2; reset_n = 1;
    step("rst_glitch");
    reset_n = 0;
    step("rst_edge");
    load(8'hA5);
    reset_n = 0; set_n = 0;
    step("rst_over_set");
    reset_n = 1; set_n = 1;

    // Set wins over load, then the load takes effect.
    set_n = 0; en = 1; mode = 2'b11; d = 8'h3C;
    step("set");
    set_n = 1;
    step("load_after_set");

    // Single-cycle shifts and hold.
    load(8'h81);
    en = 1; mode = 2'b01; sin_r = 0;
    repeat (3) step("shl");
    mode = 2'b10; sin_l = 1;
    step("shr");
    en = 0;
    step("en_off_hold");

    // Burst of 3 left; mid-burst noise on the ignored inputs.
    load(8'h01);
    start = 1; mode = 2'b01; amt = 4'd3; sin_r = 0; en = 1;
    step("burst_start");
    for (int i = 0; i < 3; i++) begin
      start = $urandom_range(0, 1); mode = 2'(($urandom_range(0, 3)));
      d = 8'($urandom); amt = 4'($urandom_range(0, 15)); en = $urandom_range(0, 1);
      step("burst_shift");
    end
    start = 0; en = 0;
    step("burst_done");
    step("burst_after");

    // Burst aborted by set after two shifts.
    load(8'h01);
    start = 1; mode = 2'b01; amt = 4'd5; sin_r = 1;
    step("abort_start");
    start = 0;
    repeat (2) step("abort_shift");
    set_n = 0;
    step("abort_set");
    set_n = 1;
    repeat (4) step("abort_no_done");

    // Oversized count is clamped to the register width.
    load(8'h5A);
    start = 1; mode = 2'b01; amt = 4'd12; sin_r = 0;
    step("clamp_start");
    start = 0;
    repeat (9) step("clamp_run");
    step("clamp_after");

    // Start held high: a new burst is accepted in the done cycle.
    load(8'h80);
    start = 1; mode = 2'b10; amt = 4'd2; sin_l = 0;
    repeat (7) step("b2b");
    start = 0;
    repeat (3) step("b2b_tail");

    // Rotate versus plain shift.
    load(8'h81);
    en = 1; mode = 2'b01; sin_r = 0; rot = 1;
    step("rotate_shl");
    load(8'h81);
    en = 1; mode = 2'b10; sin_l = 0; rot = 1;
    step("rotate_shr");
    rot = 0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      set_n   = ($urandom_range(0, 29) != 0);
      en      = $urandom_range(0, 1);
      mode    = 2'($urandom_range(0, 3));
      d       = 8'($urandom);
      sin_r   = $urandom_range(0, 1);
      sin_l   = $urandom_range(0, 1);
      start   = ($urandom_range(0, 3) == 0);
      amt     = 4'($urandom_range(0, 15));
      rot     = $urandom_range(0, 1);
      step("random");
    end
    idle_inputs();

    // Let the monitor drain; anything left over is a missed check.
    repeat (3) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor of the single-bit D flip-flop with set/reset: a WIDTH-bit register with hold, shift-left, shift-right and parallel-load modes, plus synchronous set.
- Adds a multi-cycle burst shift: shift by amt positions over amt clocks, with a busy/done handshake.
- Used as the general-purpose storage/serialiser element in datapaths and serial links.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- AMT_W, 4, width of the amt port; must hold WIDTH (2^AMT_W > WIDTH).
- SET_VALUE, {WIDTH{1'b1}}, value loaded on set_n.

Ports:
- clk  in  1  single clock, all state updates on its rising edge.
- reset_n  in  1  synchronous active-low reset, highest priority.
- set_n  in  1  synchronous active-low set; q <= SET_VALUE.
- en  in  1  enables single-cycle mode operations while IDLE.
- mode  in  2  00 hold, 01 shift left, 10 shift right, 11 parallel load.
- d  in  WIDTH  parallel load data.
- sin_r  in  1  serial input entering bit 0 on a left shift.
- sin_l  in  1  serial input entering bit WIDTH-1 on a right shift.
- start  in  1  burst request, IDLE only.
- amt  in  AMT_W  burst shift count.
- q  out  WIDTH  register contents.
- sout_l  out  1  q[WIDTH-1], combinational from q.
- sout_r  out  1  q[0], combinational from q.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the last burst shift.
- rot  in  1  rotate select; present only with USR_ROTATE_EN.

Behaviour:
- Clock and reset: single clock clk; reset_n is synchronous and active-low. Asserting reset_n without a clock edge changes nothing.
- Priority per edge: reset_n, then set_n, then burst, then en/mode.
- Reset (reset_n=0 at edge): q=0, busy=0, done=0, state=IDLE, counter=0. Aborts any burst.
- Set (set_n=0, reset_n=1): q=SET_VALUE, busy=0, done=0, state=IDLE. Aborts any burst; done is not pulsed.
- IDLE, start=0 or burst not honoured, en=1:
  - 00: hold.
  - 01: q <= {q[WIDTH-2:0], sin_r}.
  - 10: q <= {sin_l, q[WIDTH-1:1]}.
  - 11: q <= d.
  - en=0: hold.
- Burst honoured only when IDLE, start=1, mode is 01 or 10, and amt != 0. Otherwise start is ignored and the normal en/mode rule applies.
- Burst timing:
  - Edge k (start sampled): q unchanged; direction latched from mode; cnt <= min(amt, WIDTH); busy <= 1; state=BURST. amt > WIDTH is clamped to WIDTH.
  - Edges k+1..k+N: one shift per edge in the latched direction. sin_r/sin_l are sampled live each edge; cnt decrements.
  - Edge k+N: busy <= 0, done <= 1, state=IDLE.
  - Edge k+N+1: done <= 0. The normal en/mode rule applies again from this edge.
  - Net result: busy is high exactly N cycles and done is high exactly 1 cycle.
- During BURST: en, mode, d, start and amt are ignored; only reset_n and set_n interrupt.
- done is a pure one-cycle pulse. A new start on the cycle done is high is honoured.

Optional Feature:
- Macro: USR_ROTATE_EN.
- Defined: adds input rot. When rot=1, left shifts feed q[WIDTH-1] into bit 0 and right shifts feed q[0] into bit WIDTH-1 instead of sin_r/sin_l. Applies to single-cycle and burst shifts; rot is sampled each edge.
- Undefined: no rot port; shifts always use sin_r/sin_l.

Test Plan:
- Reset: q=0xA5, reset_n=0 pulsed low between edges -> q stays 0xA5. reset_n=0 across an edge -> q=0x00, busy=0, done=0. reset_n=0 and set_n=0 together -> q=0x00.
- Set/load: set_n=0, en=1, mode=11, d=0x3C -> q=0xFF. Next cycle set_n=1 -> q=0x3C.
- Single shifts: load 0x81; mode=01, sin_r=0, en=1 for 3 edges -> 0x02, 0x04, 0x08. Then mode=10, sin_l=1 -> 0x84. en=0 -> q holds 0x84.
- Burst: q=0x01, start=1, mode=01, amt=3, sin_r=0 -> busy high 3 cycles, q=0x02, 0x04, 0x08, then done=1 for one cycle. Toggling mode/d/start mid-burst has no effect.
- Abort/clamp: burst amt=5 with set_n=0 after 2 shifts -> q=0xFF, busy=0, done never pulses. amt=12 with WIDTH=8 -> busy 8 cycles, q=0x00 with sin_r=0.
- Rotate: q=0x81, mode=01, en=1. With USR_ROTATE_EN and rot=1 -> q=0x03. Without the macro, sin_r=0 -> q=0x02.
